// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one single-port memory between a fetch port and a data port, one access in flight
module memory_port_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_enable,
    input  logic [31:0] i_address,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_enable,
    input  logic        d_state,
    input  logic [31:0] d_address,
    input  logic [3:0]  d_frame_mask,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        bus_error,
    output logic        mem_enable,
    output logic        mem_state,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_frame_mask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_n;
    logic owner;
    logic err;
    logic [31:0] streak;
    logic [31:0] wd;
    logic grant_d, grant_i, hit, timeout;
    always_comb begin
        grant_d = d_enable && (!i_enable || streak != 32'(MAX_DATA_STREAK));
        grant_i = i_enable && !grant_d;
        hit     = state == ACCESS && mem_ready;
        timeout = state == ACCESS && !mem_ready && TIMEOUT_CYCLES != 0 && wd == 32'(TIMEOUT_CYCLES - 1);
        state_n = state;
        if (state == IDLE && (grant_d || grant_i))
            state_n = ACCESS;
        else if (state == ACCESS && (hit || timeout))
            state_n = RESP;
        else if (state == RESP)
            state_n = IDLE;
    end
    assign mem_enable = state == ACCESS;
    assign i_ready    = state == RESP && !owner;
    assign d_ready    = state == RESP && owner;
    assign bus_error  = state == RESP && err;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            owner          <= 1'b0;
            err            <= 1'b0;
            streak         <= '0;
            wd             <= '0;
            mem_state      <= 1'b0;
            mem_address    <= '0;
            mem_frame_mask <= '0;
            mem_wdata      <= '0;
            i_rdata        <= '0;
            d_rdata        <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && (grant_d || grant_i)) begin
                owner          <= grant_d;
                err            <= 1'b0;
                wd             <= '0;
                mem_state      <= grant_d && d_state;
                mem_address    <= grant_d ? d_address : i_address;
                mem_frame_mask <= grant_d ? d_frame_mask : 4'b1111;
                mem_wdata      <= grant_d ? d_wdata : 32'h0;
                streak         <= grant_d && i_enable ? streak + 32'd1 : 32'd0;
            end
            if (state == ACCESS) begin
                wd <= wd + 32'd1;
                if (hit && !mem_state) begin
                    if (owner) d_rdata <= mem_rdata;
                    else       i_rdata <= mem_rdata;
                end
                if (timeout) begin
                    err <= 1'b1;
                    if (owner) d_rdata <= '0;
                    else       i_rdata <= '0;
                end
            end
        end
    end
endmodule
